// File: rtl/demux1_8_seq.sv
// demux1_8_seq: sequenced 1:8 demultiplexer/deserializer with a slot counter steering din into a frame on y.
// Define DEMUX_PARITY_CHK_EN to add a 9th even-parity slot and the parity_err output.
module demux1_8_seq #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    input  logic               sync,
    output logic [8*WIDTH-1:0] y,
    output logic               frame_valid,
    output logic               sync_err,
    output logic               locked,
`ifdef DEMUX_PARITY_CHK_EN
    output logic               parity_err,
    output logic [3:0]         slot
`else
    output logic [2:0]         slot
`endif
);
`ifdef DEMUX_PARITY_CHK_EN
    localparam int SW = 4;
`else
    localparam int SW = 3;
`endif
    localparam logic [SW-1:0] LAST = SW'(SW == 4 ? 8 : 7);
    // Lanes held in the shadow; without parity, lane 7 goes straight from din to y.
    localparam int NL = SW == 4 ? 8 : 7;
    typedef enum logic {HUNT, COLLECT} state_t;
    state_t state, state_nxt;
    logic [SW-1:0] slot_nxt;
    logic [NL*WIDTH-1:0] sh;
    logic [2:0] lane;
    logic wr, done, err;
    assign locked = (state == COLLECT);
    assign lane = sync ? 3'd0 : slot[2:0];
    always_comb begin
        state_nxt = state;
        slot_nxt = slot;
        wr = 1'b0;
        done = 1'b0;
        err = 1'b0;
        if (din_valid) begin
            if (state == HUNT) begin
                if (sync) begin
                    state_nxt = COLLECT;
                    slot_nxt = SW'(1);
                    wr = 1'b1;
                end
            end else if (sync) begin
                err = (slot != '0);
                slot_nxt = SW'(1);
                wr = 1'b1;
            end else if (slot == LAST) begin
                done = 1'b1;
                slot_nxt = '0;
            end else begin
                wr = 1'b1;
                slot_nxt = slot + SW'(1);
            end
        end
    end
`ifdef DEMUX_PARITY_CHK_EN
    logic [WIDTH-1:0] par;
    always_comb begin
        par = din;
        for (int i = 0; i < 8; i++) par ^= sh[i*WIDTH +: WIDTH];
    end
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            slot <= '0;
            sh <= '0;
            y <= '0;
            frame_valid <= 1'b0;
            sync_err <= 1'b0;
`ifdef DEMUX_PARITY_CHK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            slot <= slot_nxt;
            frame_valid <= done;
            sync_err <= err;
            if (wr) sh[lane*WIDTH +: WIDTH] <= din;
`ifdef DEMUX_PARITY_CHK_EN
            if (done) y <= sh;
            parity_err <= done && |par;
`else
            if (done) y <= {din, sh};
`endif
        end
    end
endmodule

// File: doc/demux1_8_seq.md
Name: demux1_8_seq

Overview:
- Sequenced 1:8 demultiplexer and deserializer. It is the receive-side counterpart of the 8:1 mux path.
- A serial stream of WIDTH-bit words arrives one slot at a time. A 3-bit slot counter steers each word to lane D0..D7.
- When slot 7 is captured, the complete frame is presented in parallel on Y.
- Sits downstream of the mux8_1 serializer/channel and feeds parallel consumers.

Parameters:
- WIDTH, 1, bit width of each lane word (1..16).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- din  input  WIDTH  serial slot word
- din_valid  input  1  din is valid this cycle
- sync  input  1  marks din as slot 0 of a frame; qualified by din_valid
- y  output  8*WIDTH  parallel frame; lane i at y[i*WIDTH +: WIDTH] (D0 at LSBs)
- frame_valid  output  1  one-cycle pulse: y updated with a new complete frame
- sync_err  output  1  one-cycle pulse: sync arrived mid-frame, partial frame dropped
- locked  output  1  block is aligned to a frame (in COLLECT)
- slot  output  3  slot index the next valid word will be written to

Behaviour:
- Reset is asynchronous, active-low, and applies immediately.
  - Outputs: y=0, frame_valid=0, sync_err=0, locked=0, slot=0.
  - Internal: shadow register=0, state=HUNT.
- States: HUNT, COLLECT.
- HUNT:
  - din_valid without sync is ignored; slot stays 0.
  - din_valid & sync: write din to shadow lane 0, set slot=1, go to COLLECT, set locked=1.
- COLLECT, on each din_valid:
  - sync=0 and slot<7: write shadow[slot]=din, then slot++.
  - sync=0 and slot==7: on the same edge, load y from shadow lanes 0..6 plus din as lane 7. Set frame_valid=1 for the next cycle and wrap slot to 0. Stay in COLLECT, so frames are continuous.
  - sync=1 and slot==0: normal frame start. Write lane 0 and set slot=1.
  - sync=1 and slot!=0: misalignment.
    - Discard the partial shadow contents; y is untouched.
    - Pulse sync_err for one cycle.
    - Restart the frame with din as lane 0; slot=1.
- COLLECT, when din_valid=0: hold state, no writes. Gaps between slots are unlimited.
- sync when din_valid=0 is ignored in all states.
- Latency: y and frame_valid change on the clock edge that captures slot 7. frame_valid is high for exactly one cycle after that edge.
- y holds the last complete frame until the next complete frame. A partial or aborted frame never reaches y.
- Shadow lanes not yet written in the current frame keep stale data. They are always overwritten before the frame completes.
- Back-to-back frames: the slot 0 write of frame N+1 may occur on the cycle after frame N's slot 7. frame_valid then pulses once per frame with no bubble.
- Reset asserted mid-frame: partial frame is lost, y is cleared, state returns to HUNT.

Optional Feature:
- Macro: DEMUX_PARITY_CHK_EN.
- Defined:
  - The frame is extended to 9 slots; slot counter width becomes 4, and the slot port becomes 4 bits.
  - Slot 8 carries a WIDTH-bit even-parity word.
  - Lane 7 is written into shadow only; y, frame_valid and the wrap to slot 0 occur on the slot 8 capture.
  - Check: XOR-reduce over all 8 lanes plus the parity word must equal 0.
  - Extra output parity_err (1 bit, reset 0): pulses with frame_valid on a failed check. y still updates.
  - sync mid-frame at slot 8 is handled as misalignment.
- Undefined:
  - 8-slot frame as described above.
  - No parity_err port; slot is 3 bits.

Test Plan:
1. rst_n=0 then release. Apply din_valid=1 with sync=0 and din=1 for 5 cycles. Required: locked=0, slot=0, y=0, no frame_valid.
2. WIDTH=1. Feed sync on slot 0, then bits D0..D7 = 1,0,1,1,0,0,1,0 on consecutive cycles. Required: y=8'b01001101; frame_valid high for exactly 1 cycle after the slot 7 edge; slot returns to 0.
3. Two back-to-back frames, A5 then 3C (lane bits LSB first), with din_valid toggling 1/0 every cycle. Required:
   - y=8'hA5 after frame 1.
   - y=8'h3C after frame 2.
   - Exactly two frame_valid pulses.
4. After 4 slots of a frame, assert sync with din=1. Required:
   - sync_err pulses once; y is unchanged.
   - The next 7 slots complete a frame whose lane 0 is 1.
5. Pull rst_n low asynchronously (between edges) at slot 5 of a frame. Required: y=0, locked=0 and slot=0 immediately, without waiting for a clock edge. A following sync frame decodes correctly.
6. With DEMUX_PARITY_CHK_EN, WIDTH=1:
   - Frame 8'hA5 with parity bit 0: frame_valid=1, parity_err=0.
   - Same frame with parity bit 1: parity_err=1 coincident with frame_valid.
